// File: rtl/stream_out_ctrl.sv
// Streams an encoded-HV burst from the upstream buffer to an AXI4-Stream master.
// Reads are issued only with free FIFO credit, so the 1-cycle read latency never overflows the skid FIFO.
module stream_out_ctrl #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              stream_v,
  output logic [ADDR_W-1:0] stream_a,
  input  logic [DATA_W-1:0] stream_d,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     issued;
  logic [ADDR_W:0]     pop_cnt;
  logic                cap_v;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         fifo_count;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [CW-1:0]       credit_sum;
  logic                load;
  logic                issue_en;
  logic                push;
  logic                pop;

  // Words already buffered plus reads still travelling through the read latency.
  assign credit_sum    = CW'(fifo_count) + CW'(stream_v) + CW'(cap_v);
  assign push          = cap_v;
  assign m_axis_tvalid = (fifo_count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (pop_cnt == (len_q - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    issue_en   = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        issue_en = (issued < len_q) && (credit_sum < CW'(FIFO_DEPTH));
        if (pop && m_axis_tlast) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accepting a burst issues address 0 straight away; later issues follow the credit rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      issued   <= '0;
      pop_cnt  <= '0;
      stream_v <= 1'b0;
      stream_a <= '0;
      cap_v    <= 1'b0;
    end else begin
      cap_v <= stream_v;
      if (load) begin
        len_q    <= len;
        issued   <= (ADDR_W+1)'(1);
        pop_cnt  <= '0;
        stream_v <= 1'b1;
        stream_a <= '0;
      end else begin
        stream_v <= issue_en;
        if (issue_en) begin
          stream_a <= issued[ADDR_W-1:0];
          issued   <= issued + (ADDR_W+1)'(1);
        end
        if (pop) pop_cnt <= pop_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stream_d;
  end

endmodule

// File: tb/tb_stream_out_ctrl.sv
// Self-checking bench for stream_out_ctrl: a cycle table for a short burst and len=0,
// then hand-written stall, restart-ignore, async-reset and long random-backpressure sequences.
module tb_stream_out_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              stream_v;
  logic [ADDR_W-1:0] stream_a;
  logic [DATA_W-1:0] stream_d = 32'hDEADBEEF;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;

  logic [31:0]       base = 32'h0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                done_cnt = 0;
  logic [31:0]       data_q[$];
  logic              last_q[$];
  logic [7:0]        addr_q[$];

  typedef struct {
    logic        start;
    logic [8:0]  len;
    logic        tready;
    logic [63:0] exp;
  } vec_t;

  vec_t vec_q[$];

  stream_out_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .stream_v      (stream_v),
    .stream_a      (stream_a),
    .stream_d      (stream_d),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Upstream buffer: word k reads as base+k one cycle after its strobe.
  always @(posedge clk) stream_d <= stream_v ? (base + 32'(stream_a)) : 32'hDEADBEEF;

  // Records issues, pops and done pulses mid-cycle, after inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (stream_v) addr_q.push_back(stream_a);
      if (m_axis_tvalid && m_axis_tready) begin
        data_q.push_back(m_axis_tdata);
        last_q.push_back(m_axis_tlast);
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [63:0] pack(logic sv, logic [7:0] sa, logic tv, logic [31:0] td,
                                       logic tl, logic bz, logic dn);
    return {19'd0, sv, sa, tv, td, tl, bz, dn};
  endfunction

  function automatic logic [63:0] dut_outputs();
    return pack(stream_v, stream_a, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done);
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic st, input logic [8:0] l, input logic tr, input logic sv,
                         input logic [7:0] sa, input logic tv, input logic [31:0] td,
                         input logic tl, input logic bz, input logic dn);
    vec_t v;
    v.start  = st;
    v.len    = l;
    v.tready = tr;
    v.exp    = pack(sv, sa, tv, td, tl, bz, dn);
    vec_q.push_back(v);
  endtask

  task automatic clear_logs();
    data_q.delete();
    last_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic apply_stimulus(input logic [8:0] l, input logic [31:0] b);
    @(negedge clk);
    clear_logs();
    base  = b;
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input int bound, input string name, input logic random_ready);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk);
      if (random_ready) m_axis_tready = 1'($urandom_range(0, 1));
      #3;
      n++;
    end
    check_output({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic check_burst(input int n, input logic [31:0] b, input string name);
    int data_err = 0;
    int last_err = 0;
    int addr_err = 0;
    check_output({name, "_word_count"}, 64'(data_q.size()), 64'(n));
    check_output({name, "_addr_count"}, 64'(addr_q.size()), 64'(n));
    for (int k = 0; k < data_q.size(); k++) begin
      if (data_q[k] !== b + 32'(k)) data_err++;
      if (last_q[k] !== (k == n - 1)) last_err++;
    end
    for (int k = 0; k < addr_q.size(); k++) begin
      if (addr_q[k] !== 8'(k)) addr_err++;
    end
    check_output({name, "_data_order_errors"}, 64'(data_err), 64'd0);
    check_output({name, "_tlast_errors"}, 64'(last_err), 64'd0);
    check_output({name, "_addr_order_errors"}, 64'(addr_err), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    m_axis_tready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_output("reset_outputs", dut_outputs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // len=4 with tready high, then a start ignored in DONE, then len=0.
    base = 32'hA0;
    add_vec(1, 9'd4, 1, 0, 8'd0, 0, 32'h0,  0, 0, 0);
    add_vec(0, 9'd0, 1, 1, 8'd0, 0, 32'h0,  0, 1, 0);
    add_vec(0, 9'd0, 1, 1, 8'd1, 0, 32'h0,  0, 1, 0);
    add_vec(0, 9'd0, 1, 1, 8'd2, 1, 32'hA0, 0, 1, 0);
    add_vec(0, 9'd0, 1, 1, 8'd3, 1, 32'hA1, 0, 1, 0);
    add_vec(0, 9'd0, 1, 0, 8'd3, 1, 32'hA2, 0, 1, 0);
    add_vec(0, 9'd0, 1, 0, 8'd3, 1, 32'hA3, 1, 1, 0);
    add_vec(1, 9'd2, 1, 0, 8'd3, 0, 32'h0,  0, 1, 1);
    add_vec(0, 9'd0, 1, 0, 8'd3, 0, 32'h0,  0, 0, 0);
    add_vec(1, 9'd0, 1, 0, 8'd3, 0, 32'h0,  0, 0, 0);
    add_vec(0, 9'd0, 1, 0, 8'd3, 0, 32'h0,  0, 1, 1);
    add_vec(0, 9'd0, 1, 0, 8'd3, 0, 32'h0,  0, 0, 0);
    foreach (vec_q[i]) begin
      @(negedge clk);
      start         = vec_q[i].start;
      len           = vec_q[i].len;
      m_axis_tready = vec_q[i].tready;
      #1;
      check_output($sformatf("table_cycle_%0d", i), dut_outputs(), vec_q[i].exp);
    end
    start = 1'b0;
    len   = '0;

    // len=8 with 12 stalled cycles: only FIFO_DEPTH reads may be issued.
    m_axis_tready = 1'b0;
    apply_stimulus(9'd8, 32'h100);
    repeat (10) @(negedge clk);
    #3;
    check_output("stall_issue_count", 64'(addr_q.size()), 64'd4);
    check_output("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_output("stall_tdata_word0", 64'(m_axis_tdata), 64'h100);
    check_output("stall_tlast", 64'(m_axis_tlast), 64'd0);
    @(negedge clk);
    m_axis_tready = 1'b1;
    wait_done(100, "stall", 1'b0);
    check_burst(8, 32'h100, "stall");

    // A second start mid-burst must not disturb the running len=5 burst.
    apply_stimulus(9'd5, 32'h200);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd3;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    wait_done(100, "restart", 1'b0);
    repeat (4) @(negedge clk);
    #3;
    check_burst(5, 32'h200, "restart");
    check_output("restart_idle_busy", 64'(busy), 64'd0);

    // Asynchronous reset after two pops, then a fresh len=2 burst.
    apply_stimulus(9'd6, 32'h300);
    n = 0;
    while (data_q.size() < 2 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_output("midreset_two_pops", 64'(data_q.size() >= 2), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("midreset_outputs", dut_outputs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(9'd2, 32'h400);
    wait_done(100, "after_reset", 1'b0);
    check_burst(2, 32'h400, "after_reset");

    // Full-size burst under random backpressure.
    apply_stimulus(9'd256, 32'h1000);
    wait_done(3000, "long", 1'b1);
    check_burst(256, 32'h1000, "long");
    if (addr_q.size() > 0) check_output("long_last_addr", 64'(addr_q[addr_q.size()-1]), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
